// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit driving a byte-addressed, little-endian RAM data
// port. One request at a time; sub-word stores are done as read-modify-write.
module mem_lsu #(
    parameter int MEM_SIZE = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rd,
    output logic        mem_we,
    output logic [31:0] mem_wd
);

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_SIZE);

    state_t      state;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] wdata_q;
    logic        mem_we_q;

    logic        funct3_ok;
    logic        align_ok;
    logic        req_illegal;
    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic [31:0] lane_mask;
    logic [31:0] merge_data;

    // A reset edge must never carry a RAM write, whatever the state.
    assign mem_we = mem_we_q & ~rst;

    // Classify the incoming request as legal or illegal.
    always_comb begin
        funct3_ok = 1'b0;
        align_ok  = 1'b1;
        if (req_we) begin
            funct3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                        (req_funct3 == 3'b010);
        end else begin
            funct3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                        (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                        (req_funct3 == 3'b101);
        end
        case (req_funct3[1:0])
            2'b01:   align_ok = ~req_addr[0];
            2'b10:   align_ok = (req_addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
        req_illegal = ~(funct3_ok && align_ok && (req_addr < MEM_LIMIT));
    end

    // Lane extraction for loads and lane merge for sub-word stores.
    always_comb begin
        shamt   = {addr_lo_q, 3'b000};
        shifted = mem_rd >> shamt;
        case (funct3_q)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'h000000, shifted[7:0]};
            3'b101:  load_data = {16'h0000, shifted[15:0]};
            default: load_data = mem_rd;
        endcase
        lane_mask  = ((funct3_q[1:0] == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << shamt;
        merge_data = (mem_rd & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
    end

    // Request sequencing FSM; all port outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_we_q   <= 1'b0;
            mem_addr   <= '0;
            mem_wd     <= '0;
            we_q       <= 1'b0;
            funct3_q   <= '0;
            addr_lo_q  <= '0;
            wdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        funct3_q  <= req_funct3;
                        addr_lo_q <= req_addr[1:0];
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        if (req_illegal) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state    <= ACCESS;
                            mem_addr <= {req_addr[31:2], 2'b00};
                            // A full-word store writes during ACCESS, so its
                            // strobe and data are set up on acceptance.
                            mem_we_q <= req_we && (req_funct3 == 3'b010);
                            mem_wd   <= (req_we && (req_funct3 == 3'b010)) ? req_wdata : '0;
                        end
                    end
                end
                ACCESS: begin
                    if (we_q && (funct3_q != 3'b010)) begin
                        state    <= WRITE;
                        mem_we_q <= 1'b1;
                        mem_wd   <= merge_data;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= we_q ? '0 : load_data;
                        mem_we_q   <= 1'b0;
                        mem_wd     <= '0;
                        mem_addr   <= '0;
                    end
                end
                WRITE: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    mem_we_q   <= 1'b0;
                    mem_wd     <= '0;
                    mem_addr   <= '0;
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    req_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed and randomized checks of mem_lsu against a byte-level
// reference memory model.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_rd;
    logic        mem_we;
    logic [31:0] mem_wd;

    int checks = 0;
    int errors = 0;

    // RAM attached to the DUT
    logic [31:0] ram [1024];
    int          we_count = 0;
    logic [31:0] last_wd;
    logic [31:0] last_waddr;

    // Reference model: flat byte array
    logic [7:0]  ref_mem [4096];

    mem_lsu #(.MEM_SIZE(4096)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_we     (mem_we),
        .mem_wd     (mem_wd)
    );

    always #5 clk = ~clk;

    assign mem_rd = ram[mem_addr[11:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr[11:2]] <= mem_wd;
            we_count++;
            last_wd    = mem_wd;
            last_waddr = mem_addr;
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] word);
        ram[addr[11:2]] = word;
        for (int i = 0; i < 4; i++)
            ref_mem[{addr[11:2], 2'b00} + i] = word[8*i +: 8];
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        logic [31:0] w;
        for (int i = 0; i < 4; i++)
            w[8*i +: 8] = ref_mem[{addr[11:2], 2'b00} + i];
        return w;
    endfunction

    // Behavioural model of one request: result, error, latency and write count.
    task automatic ref_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                          output int lat, output int writes);
        logic legal;
        int   size;
        logic [31:0] v;
        legal = we ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size  = 1 << f3[1:0];
        err   = !legal || (addr >= 32'd4096) || ((addr % size) != 0);
        rdata = 32'h0;
        writes = 0;
        if (err) begin
            lat = 1;
        end else if (!we) begin
            v = 32'h0;
            for (int i = 0; i < size; i++)
                v = v | (32'(ref_mem[addr + i]) << (8 * i));
            if (!f3[2] && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
            if (!f3[2] && size == 2 && v[15]) v = v | 32'hFFFF_0000;
            rdata = v;
            lat = 2;
        end else begin
            for (int i = 0; i < size; i++)
                ref_mem[addr + i] = 8'(wdata >> (8 * i));
            lat = (size == 4) ? 2 : 3;
            writes = 1;
        end
    endtask

    // Issue one request, wait (bounded) for its response and check everything.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag, output logic [31:0] got_rd);
        logic        exp_err;
        logic [31:0] exp_rd;
        int          exp_lat, exp_w, w0, lat;
        ref_op(we, f3, addr, wdata, exp_err, exp_rd, exp_lat, exp_w);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        w0 = we_count;
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        got_rd = resp_rdata;
        chk({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " resp_err"}, 32'(resp_err), 32'(exp_err));
        chk({tag, " resp_rdata"}, resp_rdata, exp_rd);
        chk({tag, " write count"}, 32'(we_count - w0), 32'(exp_w));
        chk({tag, " mem word"}, ram[addr[11:2]], ref_word(addr));
    endtask

    logic [31:0] rd;
    logic [2:0]  load_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    int          w0;
    int          acc_cyc [4];
    int          resp_cyc [4];
    logic [31:0] resp_val [4];
    logic        ready_hist [12];
    int          n_acc, n_resp;
    logic        just_acc;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst resp_err", 32'(resp_err), 32'd0);
        chk("rst resp_rdata", resp_rdata, 32'h0);
        chk("rst mem_we", 32'(mem_we), 32'd0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst mem_wd", mem_wd, 32'h0);
        rst = 1'b0;

        // Load extension
        preload(32'h100, 32'h80FF7F01);
        preload(32'h104, 32'h13572468);
        do_req(1'b0, 3'b000, 32'h102, 32'h0, "LB", rd);  chk("LB value", rd, 32'hFFFFFFFF);
        do_req(1'b0, 3'b100, 32'h102, 32'h0, "LBU", rd); chk("LBU value", rd, 32'h000000FF);
        do_req(1'b0, 3'b001, 32'h102, 32'h0, "LH", rd);  chk("LH value", rd, 32'hFFFF80FF);
        do_req(1'b0, 3'b101, 32'h102, 32'h0, "LHU", rd); chk("LHU value", rd, 32'h000080FF);
        do_req(1'b0, 3'b010, 32'h100, 32'h0, "LW", rd);  chk("LW value", rd, 32'h80FF7F01);

        // Sub-word and word stores
        do_req(1'b1, 3'b000, 32'h101, 32'hDEADBEAA, "SB", rd);
        chk("SB mem_wd", last_wd, 32'h80FFAA01);
        chk("SB mem_addr", last_waddr, 32'h100);
        chk("SB word", ram[64], 32'h80FFAA01);
        preload(32'h100, 32'h80FF7F01);
        do_req(1'b1, 3'b001, 32'h102, 32'h00001234, "SH", rd);
        chk("SH word", ram[64], 32'h12347F01);
        do_req(1'b1, 3'b010, 32'h100, 32'hCAFEBABE, "SW", rd);
        chk("SW word", ram[64], 32'hCAFEBABE);
        preload(32'h100, 32'h80FF7F01);

        // Errors
        do_req(1'b0, 3'b001, 32'h101, 32'h0, "err LH mis", rd);
        do_req(1'b1, 3'b010, 32'h102, 32'h11111111, "err SW mis", rd);
        do_req(1'b0, 3'b010, 32'h1000, 32'h0, "err LW range", rd);
        do_req(1'b0, 3'b011, 32'h100, 32'h0, "err load f3", rd);
        do_req(1'b1, 3'b100, 32'h100, 32'h22222222, "err store f3", rd);
        chk("err word intact", ram[64], 32'h80FF7F01);

        // Backpressure: two queued loads with req_valid held high
        n_acc = 0; n_resp = 0; just_acc = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            if (just_acc) begin
                if (n_acc < 2) req_addr = 32'h104;
                else req_valid = 1'b0;
                just_acc = 1'b0;
            end
            ready_hist[c] = req_ready;
            if (resp_valid && n_resp < 4) begin
                resp_cyc[n_resp] = c; resp_val[n_resp] = resp_rdata; n_resp++;
            end
            if (req_valid && req_ready && n_acc < 4) begin
                acc_cyc[n_acc] = c; n_acc++; just_acc = 1'b1;
            end
        end
        req_valid = 1'b0;
        chk("bp accepts", 32'(n_acc), 32'd2);
        chk("bp resp pulses", 32'(n_resp), 32'd2);
        chk("bp ready low ACCESS", 32'(ready_hist[1]), 32'd0);
        chk("bp ready low RESP", 32'(ready_hist[2]), 32'd0);
        chk("bp first resp cycle", 32'(resp_cyc[0]), 32'(acc_cyc[0] + 2));
        chk("bp second accept", 32'(acc_cyc[1]), 32'(resp_cyc[0] + 1));
        chk("bp rdata 1", resp_val[0], ref_word(32'h100));
        chk("bp rdata 2", resp_val[1], ref_word(32'h104));

        // Reset while in WRITE during SB
        w0 = we_count;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h100; req_wdata = 32'h55;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rstwr mem_we in WRITE", 32'(mem_we), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstwr req_ready", 32'(req_ready), 32'd1);
        chk("rstwr resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        chk("rstwr resp_valid later", 32'(resp_valid), 32'd0);
        chk("rstwr writes", 32'(we_count - w0), 32'd0);
        chk("rstwr word", ram[64], 32'h80FF7F01);

        // Randomized requests
        for (int i = 0; i < 32; i++) preload(32'h100 + 32'(4 * i), $urandom);
        preload(32'hFF8, $urandom);
        preload(32'hFFC, $urandom);
        for (int i = 0; i < 60; i++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] addr;
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
            else if (we) f3 = 3'($urandom_range(0, 2));
            else f3 = load_f3[$urandom_range(0, 4)];
            case ($urandom_range(0, 9))
                0: addr = 32'hFFC + 32'($urandom_range(0, 7));
                1: addr = $urandom;
                default: addr = 32'h100 + 32'($urandom_range(0, 127));
            endcase
            do_req(we, f3, addr, $urandom, "rand", rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
